data_io_agent: RTL

//  External-side agent on the data-memory port: streams input words into the data segment, then raises

---
 rtl/data_io_agent.sv | 117 +++++++++++
 1 files changed

// File: rtl/data_io_agent.sv
// data_io_agent: external-side agent on the data-memory port.
// Loads a block of input words into the data segment, raises start_io for
// the CPU, waits for cpu_done, then streams the result words back out.
module data_io_agent #(
  parameter int WIDTH      = 32,
  parameter int LOAD_BASE  = 0,
  parameter int LOAD_WORDS = 102,
  parameter int RES_BASE   = 102,
  parameter int RES_WORDS  = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             start_io,
  input  logic             cpu_done,
  output logic             mem_own,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_a,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  localparam int MAXW = (LOAD_WORDS > RES_WORDS) ? LOAD_WORDS : RES_WORDS;
  localparam int CW   = $clog2(MAXW + 1);
  localparam logic [CW-1:0] LOAD_LAST = CW'(LOAD_WORDS - 1);
  localparam logic [CW-1:0] RES_LAST  = CW'(RES_WORDS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, FETCH, CAPTURE, OUT} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic            accept;
  logic [WIDTH-1:0] load_a, res_a;

  // Base plus zero-extended word index, wrapping at WIDTH bits.
  assign load_a = WIDTH'(LOAD_BASE) + WIDTH'(count);
  assign res_a  = WIDTH'(RES_BASE) + WIDTH'(count);
  assign accept = (state == LOAD) && in_valid;

  // Port drive: the agent only presents address/data while it owns the port,
  // so the mux sees clean zeros whenever the CPU side is selected.
  always_comb begin
    in_ready = (state == LOAD);
    mem_own  = (state == LOAD) || (state == FETCH) || (state == CAPTURE);
    mem_we   = accept;
    mem_wd   = accept ? in_data : '0;
    busy     = (state != IDLE);
    mem_a    = '0;
    if (state == LOAD)
      mem_a = load_a;
    else if (state == FETCH || state == CAPTURE)
      mem_a = res_a;
  end

  // Sequencer: load, hand off to the CPU, then fetch/capture/emit each result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      start_io  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (go) begin
          state <= LOAD;
          count <= '0;
        end
        LOAD: if (accept) begin
          if (count == LOAD_LAST) begin
            state    <= RUN;
            start_io <= 1'b1;
            count    <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        RUN: if (cpu_done) begin
          start_io <= 1'b0;
          count    <= '0;
          state    <= FETCH;
        end
        // Read data returns one cycle after the address, so FETCH only
        // presents it and CAPTURE registers it.
        FETCH: state <= CAPTURE;
        CAPTURE: begin
          out_data  <= mem_rd;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          if (count == RES_LAST) begin
            state <= IDLE;
            done  <= 1'b1;
            count <= '0;
          end else begin
            count <= count + 1'b1;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
